// File: rtl/fpga_config_loader.sv
// -----------------------------------------------------------------------------
// fpga_config_loader
//
// Receives a stream of 32-bit configuration words and builds one configuration
// frame from it. A frame is SYNC_WORD, then 16 data words, then a checksum word
// equal to the XOR of the 16 data words. The data words are collected in a
// shadow buffer. On a good checksum the buffer is copied in a single edge to
// the LUT and switch-box outputs, and the fabric is enabled. On a bad checksum
// the committed outputs stay as they were and the error flag is raised.
//
// Ports
//   clock_i       single clock, rising-edge
//   reset_i       synchronous, active-high reset
//   word_in_i     configuration word from the bitstream source
//   word_valid_i  word_in_i is valid this cycle
//   word_ready_o  always high: the loader never stalls a transfer
//   lut_mem_o     8 LUTs x 33 bits; bit 33k+32 is LUT k's register select
//   sb_cfg_o      7 switch boxes x 32 bits
//   cfg_done_o    a valid configuration is committed, fabric enabled
//   cfg_error_o   the last frame failed its checksum
//   word_count_o  data words accepted in the current frame (0..16)
// -----------------------------------------------------------------------------
module fpga_config_loader #(
  parameter logic [31:0] SYNC_WORD = 32'hAA995566
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic [31:0]  word_in_i,
  input  logic         word_valid_i,
  output logic         word_ready_o,
  output logic [263:0] lut_mem_o,
  output logic [223:0] sb_cfg_o,
  output logic         cfg_done_o,
  output logic         cfg_error_o,
  output logic [4:0]   word_count_o
);

  localparam int unsigned NUM_WORDS = 16;
  localparam int unsigned NUM_LUTS  = 8;
  localparam int unsigned NUM_SBS   = 7;
  localparam int unsigned LUT_W     = 33;
  localparam int unsigned SB_W      = 32;

  localparam logic [2:0] S_HUNT  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ERROR = 3'd4;

  localparam logic [4:0] LAST_IDX = 5'(NUM_WORDS - 1);

  logic [2:0]   state_q, state_d;
  logic [4:0]   count_q, count_d;
  logic [31:0]  csum_q, csum_d;
  logic [263:0] lut_q, lut_d;
  logic [223:0] sb_q, sb_d;
  logic         done_q, done_d;
  logic         error_q, error_d;

  logic [31:0]  shadow_q [NUM_WORDS];

  logic [263:0] lut_commit;
  logic [223:0] sb_commit;
  logic         xfer;
  logic         is_sync;
  logic         shadow_we;

  // The loader never back-pressures, so every valid word is a transfer.
  assign word_ready_o = 1'b1;
  assign xfer         = word_valid_i;
  assign is_sync      = (word_in_i == SYNC_WORD);
  assign shadow_we    = xfer && (state_q == S_LOAD);

  // Mapping from the shadow buffer to the committed fabric image. Word 15
  // carries the eight register-select bits in its top byte, MSB for LUT 0.
  // Its low 24 bits have no destination.
  always_comb begin
    lut_commit = '0;
    sb_commit  = '0;
    for (int k = 0; k < NUM_LUTS; k++) begin
      lut_commit[LUT_W*k +: 32]  = shadow_q[k];
      lut_commit[LUT_W*k + 32]   = shadow_q[NUM_WORDS-1][31-k];
    end
    for (int j = 0; j < NUM_SBS; j++) begin
      sb_commit[SB_W*j +: SB_W]  = shadow_q[NUM_LUTS + j];
    end
  end

  // NOTE: every signal assigned here gets its hold value first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    csum_d  = csum_q;
    lut_d   = lut_q;
    sb_d    = sb_q;
    done_d  = done_q;
    error_d = error_q;

    case (state_q)
      // HUNT, DONE and ERROR all look for the opening sync word. Leaving DONE
      // disables the fabric, but the old image is held until a good commit.
      // The error flag is only ever cleared by a good commit.
      S_HUNT, S_DONE, S_ERROR: begin
        if (xfer && is_sync) begin
          state_d = S_LOAD;
          count_d = '0;
          csum_d  = '0;
          done_d  = 1'b0;
        end
      end

      // Inside a frame the sync pattern is plain data. The checksum is kept
      // as a running XOR so the compare in CHECK needs no 16-input XOR tree.
      S_LOAD: begin
        if (xfer) begin
          count_d = count_q + 5'd1;
          csum_d  = csum_q ^ word_in_i;
          if (count_q == LAST_IDX) begin
            state_d = S_CHECK;
          end
        end
      end

      S_CHECK: begin
        if (xfer) begin
          count_d = '0;
          if (word_in_i == csum_q) begin
            lut_d   = lut_commit;
            sb_d    = sb_commit;
            done_d  = 1'b1;
            error_d = 1'b0;
            state_d = S_DONE;
          end else begin
            done_d  = 1'b0;
            error_d = 1'b1;
            state_d = S_ERROR;
          end
        end
      end

      default: begin
        state_d = S_HUNT;
        count_d = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the edge, whatever the block order.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= S_HUNT;
      count_q <= '0;
      csum_q  <= '0;
      lut_q   <= '0;
      sb_q    <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      csum_q  <= csum_d;
      lut_q   <= lut_d;
      sb_q    <= sb_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  // NOTE: the shadow buffer has no reset. Every entry is written before a
  // commit can read it, and a reset abandons the frame, so the contents do not
  // matter. Leaving reset off lets this map onto plain RAM or LUT storage.
  always_ff @(posedge clock_i) begin
    if (shadow_we) begin
      shadow_q[count_q[3:0]] <= word_in_i;
    end
  end

  assign lut_mem_o    = lut_q;
  assign sb_cfg_o     = sb_q;
  assign cfg_done_o   = done_q;
  assign cfg_error_o  = error_q;
  assign word_count_o = count_q;

endmodule

// File: tb/tb_fpga_config_loader.sv
// -----------------------------------------------------------------------------
// tb_fpga_config_loader
//
// Directed bench for fpga_config_loader. It sends frames word by word. Inputs
// change on the falling edge, and outputs are sampled 1 time unit after the
// rising edge. Expected images come from the bench's own frame table and from
// hand-computed constants.
// -----------------------------------------------------------------------------
module tb_fpga_config_loader;

  localparam logic [31:0] SYNC = 32'hAA995566;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  word_in;
  logic         word_valid;
  logic         word_ready;
  logic [263:0] lut_mem;
  logic [223:0] sb_cfg;
  logic         cfg_done;
  logic         cfg_error;
  logic [4:0]   word_count;

  int total = 0;
  int bad   = 0;

  logic [31:0]  frame [16];
  logic [263:0] exp_lut;
  logic [223:0] exp_sb;
  logic [263:0] held_lut;
  logic [223:0] held_sb;

  fpga_config_loader #(.SYNC_WORD(SYNC)) dut (
    .clock_i      (clk),
    .reset_i      (reset),
    .word_in_i    (word_in),
    .word_valid_i (word_valid),
    .word_ready_o (word_ready),
    .lut_mem_o    (lut_mem),
    .sb_cfg_o     (sb_cfg),
    .cfg_done_o   (cfg_done),
    .cfg_error_o  (cfg_error),
    .word_count_o (word_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [263:0] obs, input logic [263:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic [31:0] w);
    @(negedge clk);
    word_in    = w;
    word_valid = 1'b1;
    @(posedge clk);
    #1;
    word_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Frame A: data words 1..16. The XOR of 1..15 is 0, so the checksum is 0x10.
  task automatic set_frame_a();
    for (int i = 0; i < 16; i++) frame[i] = 32'(i + 1);
  endtask

  // Expected committed image, built straight from the frame table.
  task automatic build_expect();
    exp_lut = '0;
    exp_sb  = '0;
    for (int k = 0; k < 8; k++) begin
      exp_lut[33*k +: 32] = frame[k];
      exp_lut[33*k + 32]  = frame[15][31-k];
    end
    for (int j = 0; j < 7; j++) exp_sb[32*j +: 32] = frame[8+j];
  endtask

  task automatic send_frame(input logic [31:0] csum, input bit gaps);
    xfer(SYNC);
    for (int i = 0; i < 16; i++) begin
      xfer(frame[i]);
      if (gaps) idle(1);
    end
    check("count_in_check", word_count, 5'd16);
    xfer(csum);
  endtask

  initial begin
    reset      = 1'b1;
    word_in    = '0;
    word_valid = 1'b0;
    idle(2);
    reset = 1'b0;

    // Reset state
    check("rst_ready", word_ready, 1'b1);
    check("rst_lut",   lut_mem, '0);
    check("rst_sb",    sb_cfg, '0);
    check("rst_done",  cfg_done, 1'b0);
    check("rst_err",   cfg_error, 1'b0);
    check("rst_count", word_count, 5'd0);

    // Junk before sync is discarded
    xfer(32'hDEADBEEF);
    check("hunt_junk_count", word_count, 5'd0);
    xfer(SYNC);
    check("sync_count", word_count, 5'd0);

    // Reset after 7 data words, with a transfer presented on the same edge
    for (int i = 0; i < 7; i++) xfer(32'h100 + 32'(i));
    check("mid_count", word_count, 5'd7);
    @(negedge clk);
    reset      = 1'b1;
    word_in    = 32'h12345678;
    word_valid = 1'b1;
    @(posedge clk);
    #1;
    reset      = 1'b0;
    word_valid = 1'b0;
    check("midrst_count", word_count, 5'd0);
    check("midrst_lut",   lut_mem, '0);
    check("midrst_done",  cfg_done, 1'b0);

    // Nominal load
    set_frame_a();
    build_expect();
    send_frame(32'h00000010, 1'b0);
    check("a_done",  cfg_done, 1'b1);
    check("a_err",   cfg_error, 1'b0);
    check("a_count", word_count, 5'd0);
    check("a_lut0",  lut_mem[31:0], 32'h1);
    check("a_sb0",   sb_cfg[31:0], 32'h9);
    for (int k = 0; k < 8; k++) check($sformatf("a_rs%0d", k), lut_mem[33*k+32], 1'b0);
    check("a_lut", lut_mem, exp_lut);
    check("a_sb",  sb_cfg, exp_sb);

    // Idle cycles and non-sync words in DONE change nothing
    idle(3);
    xfer(32'h0BADF00D);
    check("idle_done",  cfg_done, 1'b1);
    check("idle_lut",   lut_mem, exp_lut);
    check("idle_count", word_count, 5'd0);

    // Reconfiguration: sync drops done and holds the old image
    held_lut = exp_lut;
    held_sb  = exp_sb;
    xfer(SYNC);
    check("recfg_done", cfg_done, 1'b0);
    check("recfg_lut",  lut_mem, held_lut);
    check("recfg_sb",   sb_cfg, held_sb);
    for (int i = 0; i < 16; i++) xfer(frame[i] ^ ((i == 0) ? 32'hFFFF0001 : 32'h0));
    check("recfg_hold_lut", lut_mem, held_lut);
    xfer(32'hFFFF0011);
    frame[0] = 32'hFFFF0000;
    build_expect();
    check("c_done", cfg_done, 1'b1);
    check("c_lut0", lut_mem[31:0], 32'hFFFF0000);
    check("c_lut",  lut_mem, exp_lut);

    // Register-select bits from the top byte of word 15
    set_frame_a();
    frame[15] = 32'hA5000000;
    send_frame(32'hA5000000, 1'b0);
    check("b_done", cfg_done, 1'b1);
    check("b_rs",   {lut_mem[263], lut_mem[230], lut_mem[197], lut_mem[164],
                     lut_mem[131], lut_mem[98],  lut_mem[65],  lut_mem[32]}, 8'b1010_0101);

    // The sync word inside a frame is ordinary data
    set_frame_a();
    frame[5] = SYNC;
    build_expect();
    send_frame(32'hAA995570, 1'b0);
    check("d_done", cfg_done, 1'b1);
    check("d_lut",  lut_mem, exp_lut);

    // Bad checksum from a clean reset
    do_reset();
    set_frame_a();
    send_frame(32'h00000011, 1'b0);
    check("bad_err",   cfg_error, 1'b1);
    check("bad_done",  cfg_done, 1'b0);
    check("bad_lut",   lut_mem, '0);
    check("bad_sb",    sb_cfg, '0);
    check("bad_count", word_count, 5'd0);
    xfer(32'hDEADBEEF);
    check("err_junk_count", word_count, 5'd0);
    xfer(SYNC);
    check("err_sync_err", cfg_error, 1'b1);
    for (int i = 0; i < 16; i++) xfer(frame[i]);
    check("err_load_err", cfg_error, 1'b1);
    xfer(32'h00000010);
    build_expect();
    check("fix_err",  cfg_error, 1'b0);
    check("fix_done", cfg_done, 1'b1);
    check("fix_lut",  lut_mem, exp_lut);

    // Gaps between words give the same result as the nominal load
    do_reset();
    set_frame_a();
    build_expect();
    send_frame(32'h00000010, 1'b1);
    check("gap_done", cfg_done, 1'b1);
    check("gap_lut",  lut_mem, exp_lut);
    check("gap_sb",   sb_cfg, exp_sb);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net: the bench must always end on its own.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
